// File: rtl/datamover_mc_package.sv
// rtl/datamover_mc_package.sv - shared types and defaults for the multi-channel datamover controller
//
// Contents:
//   dm_mc_state_t   : controller FSM states
//   mc_chan_ctrl_t  : per-channel command bundle towards the streamer
//   mc_chan_flags_t : per-channel completion flags from the streamer
//   DM_MC_*         : default parameter values

package datamover_mc_package;

   localparam int DM_MC_N_CH  = 2;
   localparam int DM_MC_AW    = 32;
   localparam int DM_MC_REP_W = 16;
   localparam int DM_MC_TO_W  = 20;

   typedef enum logic [2:0] {
      DM_MC_IDLE     = 3'd0,
      DM_MC_START    = 3'd1,
      DM_MC_WORK     = 3'd2,
      DM_MC_NEXT     = 3'd3,
      DM_MC_FINISHED = 3'd4
   } dm_mc_state_t;

   typedef struct packed {
      logic                src_req_start;
      logic                sink_req_start;
      logic [DM_MC_AW-1:0] src_base;
      logic [DM_MC_AW-1:0] dst_base;
   } mc_chan_ctrl_t;

   typedef struct packed {
      logic src_done;
      logic sink_done;
   } mc_chan_flags_t;

endpackage

// File: rtl/datamover_mc_chan_tracker.sv
// rtl/datamover_mc_chan_tracker.sv - per-channel base address registers and completion tracking
//
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   clear_i               : synchronous soft clear (zeroes bases and flags)
//   load_i                : capture src_base_i/dst_base_i (job start)
//   src_base_i/dst_base_i : base addresses to capture
//   incr_i                : advance bases by the increments (between passes)
//   src_incr_i/dst_incr_i : per-pass increments
//   en_i                  : channel enabled for the current job
//   flag_clr_i            : clear the sticky seen flags (pass start)
//   track_i               : done pulses are accepted (WORK state)
//   done_i                : source/sink done pulses of this channel
//   src_base_o/dst_base_o : current-pass base addresses
//   finished_o            : channel has nothing left to do in this pass

module datamover_mc_chan_tracker
   import datamover_mc_package::*;
#(
   parameter int AW = DM_MC_AW
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           clear_i,
   input  logic           load_i,
   input  logic [AW-1:0]  src_base_i,
   input  logic [AW-1:0]  dst_base_i,
   input  logic           incr_i,
   input  logic [AW-1:0]  src_incr_i,
   input  logic [AW-1:0]  dst_incr_i,
   input  logic           en_i,
   input  logic           flag_clr_i,
   input  logic           track_i,
   input  mc_chan_flags_t done_i,
   output logic [AW-1:0]  src_base_o,
   output logic [AW-1:0]  dst_base_o,
   output logic           finished_o
);

   logic [AW-1:0] src_base_q;
   logic [AW-1:0] dst_base_q;
   logic          src_seen_q;
   logic          sink_seen_q;
   logic          src_hit;
   logic          sink_hit;

   assign src_hit  = track_i & done_i.src_done;
   assign sink_hit = track_i & done_i.sink_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_base_q <= '0;
         dst_base_q <= '0;
      end else if (clear_i) begin
         src_base_q <= '0;
         dst_base_q <= '0;
      end else if (load_i) begin
         src_base_q <= src_base_i;
         dst_base_q <= dst_base_i;
      end else if (incr_i && en_i) begin
         // Wraps modulo 2^AW by construction.
         src_base_q <= src_base_q + src_incr_i;
         dst_base_q <= dst_base_q + dst_incr_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_seen_q  <= 1'b0;
         sink_seen_q <= 1'b0;
      end else if (clear_i || flag_clr_i) begin
         src_seen_q  <= 1'b0;
         sink_seen_q <= 1'b0;
      end else begin
         if (src_hit)  src_seen_q  <= 1'b1;
         if (sink_hit) sink_seen_q <= 1'b1;
      end
   end

   // Pulses of the current cycle are folded in so that a final done pulse
   // completes the pass without waiting for the flag to register.
   assign finished_o = !en_i | ((src_seen_q | src_hit) & (sink_seen_q | sink_hit));

   assign src_base_o = src_base_q;
   assign dst_base_o = dst_base_q;

endmodule

// File: rtl/datamover_mc_ctrl.sv
// rtl/datamover_mc_ctrl.sv - multi-channel datamover control FSM with repeat passes and watchdog
//
// Ports:
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   clear_i                     : synchronous soft clear, aborts any job silently
//   start_i                     : job start pulse (accepted in IDLE only)
//   ch_enable_i                 : channel enable mask, sampled at start
//   repeat_i                    : number of passes (0 behaves as 1)
//   timeout_i                   : watchdog limit in cycles (0 disables)
//   src_base_i/dst_base_i       : per-channel base addresses, channel i at [i*AW +: AW]
//   src_incr_i/dst_incr_i       : base increments applied between passes
//   src_done_i/sink_done_i      : per-channel done pulses from the streamer
//   tcdm_fifo_empty_i           : streamer TCDM FIFO empty
//   src_req_start_o             : per-channel source start, one cycle per pass
//   sink_req_start_o            : per-channel sink start, one cycle per pass
//   src_base_o/dst_base_o       : current-pass base addresses
//   busy_o                      : controller not in IDLE
//   done_o                      : one-cycle job completion pulse
//   error_o                     : sticky watchdog timeout flag
//   pass_cnt_o                  : 0-based index of the current pass

module datamover_mc_ctrl
   import datamover_mc_package::*;
#(
   parameter int N_CH  = DM_MC_N_CH,
   parameter int AW    = DM_MC_AW,
   parameter int REP_W = DM_MC_REP_W,
   parameter int TO_W  = DM_MC_TO_W
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               start_i,
   input  logic [N_CH-1:0]    ch_enable_i,
   input  logic [REP_W-1:0]   repeat_i,
   input  logic [TO_W-1:0]    timeout_i,
   input  logic [N_CH*AW-1:0] src_base_i,
   input  logic [N_CH*AW-1:0] dst_base_i,
   input  logic [AW-1:0]      src_incr_i,
   input  logic [AW-1:0]      dst_incr_i,
   input  logic [N_CH-1:0]    src_done_i,
   input  logic [N_CH-1:0]    sink_done_i,
   input  logic               tcdm_fifo_empty_i,
   output logic [N_CH-1:0]    src_req_start_o,
   output logic [N_CH-1:0]    sink_req_start_o,
   output logic [N_CH*AW-1:0] src_base_o,
   output logic [N_CH*AW-1:0] dst_base_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o,
   output logic [REP_W-1:0]   pass_cnt_o
);

   dm_mc_state_t     state_q;
   logic [N_CH-1:0]  en_q;
   logic [REP_W-1:0] rep_q;
   logic [TO_W-1:0]  to_q;
   logic [TO_W-1:0]  wd_q;
   logic [REP_W-1:0] pass_cnt_q;
   logic             error_q;
   logic             done_q;
   logic [N_CH-1:0]  src_req_q;
   logic [N_CH-1:0]  sink_req_q;

   logic [N_CH-1:0]  ch_fin;
   logic             all_fin;
   logic             any_done;
   logic             wd_hit;
   logic             more_passes;
   logic [REP_W:0]   pass_nxt;
   logic             load;
   logic             flag_clr;
   logic             track;
   logic             incr;

   mc_chan_flags_t [N_CH-1:0] ch_flags;

   assign load     = (state_q == DM_MC_IDLE) && start_i;
   assign flag_clr = (state_q == DM_MC_START);
   assign track    = (state_q == DM_MC_WORK);
   assign incr     = (state_q == DM_MC_NEXT);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign ch_flags[g].src_done  = src_done_i[g];
      assign ch_flags[g].sink_done = sink_done_i[g];

      datamover_mc_chan_tracker #(
         .AW (AW)
      ) u_tracker (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .clear_i    (clear_i),
         .load_i     (load),
         .src_base_i (src_base_i[g*AW +: AW]),
         .dst_base_i (dst_base_i[g*AW +: AW]),
         .incr_i     (incr),
         .src_incr_i (src_incr_i),
         .dst_incr_i (dst_incr_i),
         .en_i       (en_q[g]),
         .flag_clr_i (flag_clr),
         .track_i    (track),
         .done_i     (ch_flags[g]),
         .src_base_o (src_base_o[g*AW +: AW]),
         .dst_base_o (dst_base_o[g*AW +: AW]),
         .finished_o (ch_fin[g])
      );
   end

   assign all_fin     = (&ch_fin) & tcdm_fifo_empty_i;
   assign any_done    = (|src_done_i) | (|sink_done_i);
   assign wd_hit      = (to_q != '0) && (wd_q == to_q - TO_W'(1));
   assign pass_nxt    = {1'b0, pass_cnt_q} + (REP_W+1)'(1);
   assign more_passes = pass_nxt < {1'b0, rep_q};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= DM_MC_IDLE;
         en_q       <= '0;
         rep_q      <= '0;
         to_q       <= '0;
         wd_q       <= '0;
         pass_cnt_q <= '0;
         error_q    <= 1'b0;
         done_q     <= 1'b0;
         src_req_q  <= '0;
         sink_req_q <= '0;
      end else if (clear_i) begin
         state_q    <= DM_MC_IDLE;
         en_q       <= '0;
         rep_q      <= '0;
         to_q       <= '0;
         wd_q       <= '0;
         pass_cnt_q <= '0;
         error_q    <= 1'b0;
         done_q     <= 1'b0;
         src_req_q  <= '0;
         sink_req_q <= '0;
      end else begin
         // Pulse outputs default low; each is raised on the transition
         // into the state it belongs to, so it is visible for that state.
         done_q     <= 1'b0;
         src_req_q  <= '0;
         sink_req_q <= '0;
         case (state_q)
            DM_MC_IDLE: begin
               if (start_i) begin
                  en_q       <= ch_enable_i;
                  rep_q      <= (repeat_i == '0) ? REP_W'(1) : repeat_i;
                  to_q       <= timeout_i;
                  error_q    <= 1'b0;
                  pass_cnt_q <= '0;
                  if (ch_enable_i == '0) begin
                     state_q <= DM_MC_FINISHED;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= DM_MC_START;
                     src_req_q  <= ch_enable_i;
                     sink_req_q <= ch_enable_i;
                  end
               end
            end
            DM_MC_START: begin
               wd_q    <= '0;
               state_q <= DM_MC_WORK;
            end
            DM_MC_WORK: begin
               // Completion takes priority over a coincident watchdog expiry.
               if (all_fin) begin
                  if (more_passes) begin
                     state_q <= DM_MC_NEXT;
                  end else begin
                     state_q <= DM_MC_FINISHED;
                     done_q  <= 1'b1;
                  end
               end else if (wd_hit) begin
                  error_q <= 1'b1;
                  state_q <= DM_MC_FINISHED;
                  done_q  <= 1'b1;
               end else if (any_done) begin
                  wd_q <= '0;
               end else begin
                  wd_q <= wd_q + TO_W'(1);
               end
            end
            DM_MC_NEXT: begin
               pass_cnt_q <= pass_cnt_q + REP_W'(1);
               state_q    <= DM_MC_START;
               src_req_q  <= en_q;
               sink_req_q <= en_q;
            end
            DM_MC_FINISHED: begin
               state_q <= DM_MC_IDLE;
            end
            default: begin
               state_q <= DM_MC_IDLE;
            end
         endcase
      end
   end

   assign src_req_start_o  = src_req_q;
   assign sink_req_start_o = sink_req_q;
   assign busy_o           = (state_q != DM_MC_IDLE);
   assign done_o           = done_q;
   assign error_o          = error_q;
   assign pass_cnt_o       = pass_cnt_q;

endmodule

// File: tb/tb_datamover_mc_ctrl.sv
// tb/tb_datamover_mc_ctrl.sv - scoreboard testbench for datamover_mc_ctrl

module tb_datamover_mc_ctrl;

   localparam int N_CH  = 2;
   localparam int AW    = 32;
   localparam int REP_W = 16;
   localparam int TO_W  = 20;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               clear = 1'b0;
   logic               start = 1'b0;
   logic [N_CH-1:0]    ch_en = '0;
   logic [REP_W-1:0]   rep = '0;
   logic [TO_W-1:0]    tmo = '0;
   logic [N_CH*AW-1:0] src_base = '0;
   logic [N_CH*AW-1:0] dst_base = '0;
   logic [AW-1:0]      src_incr = '0;
   logic [AW-1:0]      dst_incr = '0;
   logic [N_CH-1:0]    src_done = '0;
   logic [N_CH-1:0]    sink_done = '0;
   logic               fifo_empty = 1'b1;
   logic [N_CH-1:0]    src_req;
   logic [N_CH-1:0]    sink_req;
   logic [N_CH*AW-1:0] src_base_q;
   logic [N_CH*AW-1:0] dst_base_q;
   logic               busy;
   logic               done;
   logic               error;
   logic [REP_W-1:0]   pass_cnt;

   datamover_mc_ctrl #(
      .N_CH (N_CH), .AW (AW), .REP_W (REP_W), .TO_W (TO_W)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .clear_i           (clear),
      .start_i           (start),
      .ch_enable_i       (ch_en),
      .repeat_i          (rep),
      .timeout_i         (tmo),
      .src_base_i        (src_base),
      .dst_base_i        (dst_base),
      .src_incr_i        (src_incr),
      .dst_incr_i        (dst_incr),
      .src_done_i        (src_done),
      .sink_done_i       (sink_done),
      .tcdm_fifo_empty_i (fifo_empty),
      .src_req_start_o   (src_req),
      .sink_req_start_o  (sink_req),
      .src_base_o        (src_base_q),
      .dst_base_o        (dst_base_q),
      .busy_o            (busy),
      .done_o            (done),
      .error_o           (error),
      .pass_cnt_o        (pass_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_done;
      logic [1:0]  mask;
      logic [31:0] sb0, sb1, db0, db1;
      logic [15:0] pass;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: every req_start burst and every done pulse pops one
   // expected event from the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (src_req != '0 || sink_req != '0) begin
            if (sb_q.size() == 0) begin
               tb_check("unexpected_req", 64'(src_req | sink_req), 64'd0);
            end else begin
               e = sb_q.pop_front();
               tb_check("evt_is_req", 64'(e.is_done), 64'd0);
               tb_check("src_req_mask", 64'(src_req), 64'(e.mask));
               tb_check("sink_req_mask", 64'(sink_req), 64'(e.mask));
               tb_check("src_base0", 64'(src_base_q[31:0]), 64'(e.sb0));
               tb_check("src_base1", 64'(src_base_q[63:32]), 64'(e.sb1));
               tb_check("dst_base0", 64'(dst_base_q[31:0]), 64'(e.db0));
               tb_check("dst_base1", 64'(dst_base_q[63:32]), 64'(e.db1));
               tb_check("pass_cnt", 64'(pass_cnt), 64'(e.pass));
            end
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               tb_check("unexpected_done", 64'(done), 64'd0);
            end else begin
               e = sb_q.pop_front();
               tb_check("evt_is_done", 64'(e.is_done), 64'd1);
               tb_check("done_error", 64'(error), 64'(e.err));
            end
         end
      end
   end

   // Pushes the expected bursts/done, then issues the start pulse.
   task automatic start_job(input logic [1:0] en, input int r, input int t,
                            input logic [31:0] s0, s1, d0, d1, si, di,
                            input int n_bursts, input bit push_done, input bit err);
      exp_t e;
      for (int p = 0; p < n_bursts; p++) begin
         e.is_done = 1'b0;
         e.mask    = en;
         e.sb0     = en[0] ? s0 + si * 32'(p) : s0;
         e.sb1     = en[1] ? s1 + si * 32'(p) : s1;
         e.db0     = en[0] ? d0 + di * 32'(p) : d0;
         e.db1     = en[1] ? d1 + di * 32'(p) : d1;
         e.pass    = 16'(p);
         e.err     = 1'b0;
         sb_q.push_back(e);
      end
      if (push_done) begin
         e = '{is_done: 1'b1, mask: 2'b00, sb0: 32'd0, sb1: 32'd0, db0: 32'd0, db1: 32'd0,
               pass: 16'd0, err: err};
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      ch_en    = en;
      rep      = 16'(r);
      tmo      = 20'(t);
      src_base = {s1, s0};
      dst_base = {d1, d0};
      src_incr = si;
      dst_incr = di;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic wait_req(input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (src_req == '0 && n < 20);
      tb_check(tag, 64'(src_req != '0), 64'd1);
   endtask

   // Done pulses at WORK-cycle offsets (1 = first WORK cycle); -1 = never.
   task automatic serve(input int ds0, input int dk0, input int ds1, input int dk1);
      int maxd;
      maxd = ds0;
      if (dk0 > maxd) maxd = dk0;
      if (ds1 > maxd) maxd = ds1;
      if (dk1 > maxd) maxd = dk1;
      for (int c = 1; c <= maxd; c++) begin
         @(posedge clk); #1;
         src_done  = {ds1 == c, ds0 == c};
         sink_done = {dk1 == c, dk0 == c};
      end
      @(posedge clk); #1;
      src_done  = '0;
      sink_done = '0;
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      tb_check("rst_busy", 64'(busy), 64'd0);
      tb_check("rst_done", 64'(done), 64'd0);
      tb_check("rst_error", 64'(error), 64'd0);
      tb_check("rst_pass", 64'(pass_cnt), 64'd0);
      tb_check("rst_req", 64'(src_req | sink_req), 64'd0);
      tb_check("rst_base", 64'(src_base_q | dst_base_q), 64'd0);
      rst_n = 1'b1;

      // Basic single pass, both channels
      start_job(2'b11, 1, 0, 32'h100, 32'h200, 32'h300, 32'h400, 32'h0, 32'h0, 1, 1, 1'b0);
      wait_req("basic_req", n);
      tb_check("basic_req_lat", 64'(n), 64'd1);
      serve(10, 12, 15, 20);
      tb_check("basic_done_lat", 64'(done), 64'd1);
      tb_check("basic_err", 64'(error), 64'd0);
      @(posedge clk); #1;
      tb_check("basic_idle", 64'(busy), 64'd0);

      // Three passes with increments
      start_job(2'b11, 3, 0, 32'h100, 32'h200, 32'h300, 32'h400, 32'h40, 32'h80, 3, 1, 1'b0);
      for (int p = 0; p < 3; p++) begin
         wait_req("rep_req", n);
         serve(2, 3, 4, 5);
      end
      tb_check("rep_done_lat", 64'(done), 64'd1);

      // Only channel 1 enabled
      start_job(2'b10, 1, 0, 32'h100, 32'h200, 32'h300, 32'h400, 32'h0, 32'h0, 1, 1, 1'b0);
      wait_req("mask_req", n);
      serve(-1, -1, 3, 6);
      tb_check("mask_done_lat", 64'(done), 64'd1);

      // No channels: done without traffic
      start_job(2'b00, 1, 0, 32'h100, 32'h200, 32'h300, 32'h400, 32'h0, 32'h0, 0, 1, 1'b0);
      n = 0;
      while (!done && n < 2) begin
         @(posedge clk); #1;
         n++;
      end
      tb_check("en0_done", 64'(done), 64'd1);
      repeat (3) @(posedge clk);

      // repeat=0 behaves as a single pass
      start_job(2'b11, 0, 0, 32'h10, 32'h20, 32'h30, 32'h40, 32'h40, 32'h80, 1, 1, 1'b0);
      wait_req("rep0_req", n);
      serve(1, 1, 2, 2);
      tb_check("rep0_done_lat", 64'(done), 64'd1);

      // Watchdog: ch1 sink never completes
      start_job(2'b11, 1, 50, 32'h100, 32'h200, 32'h300, 32'h400, 32'h0, 32'h0, 1, 1, 1'b1);
      wait_req("to_req", n);
      serve(2, 3, 4, -1);
      n = 0;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      tb_check("to_latency", 64'(n), 64'd50);
      tb_check("to_error", 64'(error), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      tb_check("to_error_sticky", 64'(error), 64'd1);

      // Address wrap; the accepted start also clears the error flag
      start_job(2'b11, 2, 0, 32'hFFFF_FFC0, 32'h200, 32'h300, 32'h400, 32'h40, 32'h80, 2, 1, 1'b0);
      tb_check("err_cleared", 64'(error), 64'd0);
      wait_req("wrap_req0", n);
      serve(1, 2, 3, 4);
      wait_req("wrap_req1", n);
      tb_check("wrap_base", 64'(src_base_q[31:0]), 64'd0);
      serve(1, 2, 3, 4);
      tb_check("wrap_done_lat", 64'(done), 64'd1);

      // FIFO not empty holds WORK
      start_job(2'b11, 1, 0, 32'h100, 32'h200, 32'h300, 32'h400, 32'h0, 32'h0, 1, 1, 1'b0);
      wait_req("fifo_req", n);
      fifo_empty = 1'b0;
      serve(2, 3, 4, 5);
      repeat (5) @(posedge clk);
      #1;
      tb_check("fifo_hold_done", 64'(done), 64'd0);
      tb_check("fifo_hold_busy", 64'(busy), 64'd1);
      fifo_empty = 1'b1;
      @(posedge clk); #1;
      tb_check("fifo_release", 64'(done), 64'd1);

      // Completion coincides with watchdog expiry (timeout 10)
      start_job(2'b11, 1, 10, 32'h100, 32'h200, 32'h300, 32'h400, 32'h0, 32'h0, 1, 1, 1'b0);
      wait_req("coinc_req", n);
      fifo_empty = 1'b0;
      serve(2, 3, 4, 5);
      repeat (9) @(posedge clk);
      #1;
      fifo_empty = 1'b1;
      @(posedge clk); #1;
      tb_check("coinc_done", 64'(done), 64'd1);
      tb_check("coinc_error", 64'(error), 64'd0);

      // Soft clear during pass 1 of 3
      start_job(2'b11, 3, 0, 32'h100, 32'h200, 32'h300, 32'h400, 32'h40, 32'h80, 2, 0, 1'b0);
      wait_req("clr_req0", n);
      serve(2, 3, 4, 5);
      wait_req("clr_req1", n);
      repeat (2) @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      tb_check("clr_busy", 64'(busy), 64'd0);
      tb_check("clr_pass", 64'(pass_cnt), 64'd0);
      tb_check("clr_base", 64'(src_base_q | dst_base_q), 64'd0);
      tb_check("clr_done", 64'(done), 64'd0);
      repeat (10) @(posedge clk);
      tb_check("clr_sb_empty", 64'(sb_q.size()), 64'd0);

      // Asynchronous reset mid-job, then a fresh job
      start_job(2'b11, 2, 0, 32'h100, 32'h200, 32'h300, 32'h400, 32'h40, 32'h80, 1, 0, 1'b0);
      wait_req("arst_req", n);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      tb_check("arst_busy", 64'(busy), 64'd0);
      tb_check("arst_base", 64'(src_base_q | dst_base_q), 64'd0);
      tb_check("arst_pass", 64'(pass_cnt), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      start_job(2'b11, 1, 0, 32'h500, 32'h600, 32'h700, 32'h800, 32'h0, 32'h0, 1, 1, 1'b0);
      wait_req("arst_req2", n);
      serve(3, 4, 5, 6);
      tb_check("arst_done_lat", 64'(done), 64'd1);
      repeat (3) @(posedge clk);

      tb_check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
